// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sample path.
package fir_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int CLK_DIV_DEFAULT = 4;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } tx_state_t;

endpackage

// File: rtl/fir_sample_tx_if.sv
// Sample-in strobe plus serial DAC link and status, as seen by the transmitter.
interface fir_sample_tx_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);

  logic signed [WIDTH-1:0]   in;
  logic                      input_ready;
  logic                      sclk;
  logic                      fsync;
  logic                      sdata;
  logic                      busy;
  logic                      overflow;
  logic [$clog2(DEPTH):0]    level;

  modport master (
    output in, input_ready,
    input  sclk, fsync, sdata, busy, overflow, level
  );

  modport slave (
    input  in, input_ready,
    output sclk, fsync, sdata, busy, overflow, level
  );

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; a push while full is accepted only if a pop frees the head slot.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic                       push,
  input  logic signed [WIDTH-1:0]    din,
  input  logic                       pop,
  output logic signed [WIDTH-1:0]    dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    wr;
  logic                    rd;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge ck) begin
    if (wr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr, rd})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_tx.sv
// Serial sample transmitter: FIFO-buffered 16-bit samples sent MSB-first on sclk/fsync/sdata.
module fir_sample_tx
  import fir_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic           ck,
  input  logic           rst,
  fir_sample_tx_if.slave bus
);

  localparam int DIV_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(WIDTH - 1);

  tx_state_t               state, state_n;
  logic [DIV_W-1:0]        div, div_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic signed [WIDTH-1:0] shreg, shreg_n;
  logic                    pop;
  logic                    sclk_n, fsync_n, sdata_n;
  logic                    sclk_q, fsync_q, sdata_q;
  logic                    ovf_q;

  logic signed [WIDTH-1:0] head;
  logic                    full;
  logic                    empty;
  logic [LVL_W-1:0]        fifo_level;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck    (ck),
    .rst   (rst),
    .push  (bus.input_ready),
    .din   (bus.in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Next-state logic; serial outputs are derived from next-state values so they can be registered.
  always_comb begin
    state_n = state;
    div_n   = div;
    cnt_n   = cnt;
    shreg_n = shreg;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_n = LOAD;
      end
      LOAD: begin
        pop     = 1'b1;
        shreg_n = head;
        cnt_n   = CNT_TOP;
        div_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        if (div == DIV_LAST) begin
          div_n = '0;
          if (cnt == '0) begin
            state_n = GAP;
          end else begin
            cnt_n   = cnt - CNT_W'(1);
            shreg_n = shreg << 1;
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      GAP: begin
        if (div == DIV_LAST) begin
          div_n   = '0;
          state_n = empty ? IDLE : LOAD;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    sclk_n  = (state_n == SHIFT) && (div_n >= DIV_HALF);
    fsync_n = (state_n == SHIFT) && (cnt_n == CNT_TOP);
    sdata_n = (state_n == SHIFT) && shreg_n[WIDTH-1];
  end

  // Control state, counters, registered serial outputs and sticky overflow.
  always_ff @(posedge ck) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      cnt     <= '0;
      sclk_q  <= 1'b0;
      fsync_q <= 1'b0;
      sdata_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      cnt     <= cnt_n;
      sclk_q  <= sclk_n;
      fsync_q <= fsync_n;
      sdata_q <= sdata_n;
      ovf_q   <= ovf_q | (bus.input_ready & full & ~pop);
    end
  end

  // Shift register is pure data; outputs are masked by state so it needs no reset.
  always_ff @(posedge ck) begin
    shreg <= shreg_n;
  end

  assign bus.sclk     = sclk_q;
  assign bus.fsync    = fsync_q;
  assign bus.sdata    = sdata_q;
  assign bus.overflow = ovf_q;
  assign bus.level    = fifo_level;
  assign bus.busy     = (state != IDLE) || !empty;

endmodule

// File: tb/tb_fir_sample_tx.sv
// Scoreboard bench for fir_sample_tx: stimulus queues expected words, a monitor deserialises and compares.
module tb_fir_sample_tx;
  import fir_pkg::*;

  localparam int CD    = 2;
  localparam int FRAME = 1 + 34 * CD;

  logic ck  = 1'b0;
  logic rst = 1'b1;

  fir_sample_tx_if #(.WIDTH(16), .DEPTH(4)) bus ();

  fir_sample_tx #(
    .WIDTH   (16),
    .DEPTH   (4),
    .CLK_DIV (CD)
  ) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 ck = ~ck;

  int      checks   = 0;
  int      failures = 0;
  int      cyc      = 0;
  int      rises    = 0;
  sample_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge ck);
    cyc++;
  end

  // Monitor: rebuild words on rising sclk, compare each completed frame with the queue head.
  initial begin : monitor
    logic        prev;
    logic [15:0] word;
    int          nbits;
    bit          in_frame;
    sample_t     e;
    prev = 1'b0; word = '0; nbits = 0; in_frame = 0;
    forever begin
      @(negedge ck);
      if (rst) begin
        in_frame = 0;
        nbits    = 0;
        prev     = 1'b0;
      end else begin
        if (bus.sclk && !prev) begin
          rises++;
          if (!in_frame) begin
            check("frame_fsync_first", {31'b0, bus.fsync}, 32'd1);
            in_frame = 1;
            nbits    = 0;
          end else begin
            check("frame_fsync_low", {31'b0, bus.fsync}, 32'd0);
          end
          word = {word[14:0], bus.sdata};
          nbits++;
          if (nbits == 16) begin
            in_frame = 0;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL frame_unexpected actual=%0h required=none", word);
            end else begin
              e = exp_q.pop_front();
              check("frame_word", {16'h0, word}, {16'h0, e});
            end
          end
        end
        prev = bus.sclk;
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge ck);
  endtask

  task automatic push(input logic [15:0] v, input bit queued, output int t);
    bus.in          = v;
    bus.input_ready = 1'b1;
    t               = cyc;
    if (queued) exp_q.push_back(v);
    @(negedge ck);
    bus.input_ready = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n;
    n = 0;
    while (bus.busy && n < maxc) begin
      @(negedge ck);
      n++;
    end
    check({name, "_idle"}, {31'b0, bus.busy}, 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_fsync(input int maxc, output int c);
    int n;
    n = 0;
    while (!bus.fsync && n < maxc) begin
      @(negedge ck);
      n++;
    end
    c = cyc;
    check("fsync_seen", {31'b0, bus.fsync}, 32'd1);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_sclk"},     {31'b0, bus.sclk},     32'd0);
    check({name, "_fsync"},    {31'b0, bus.fsync},    32'd0);
    check({name, "_sdata"},    {31'b0, bus.sdata},    32'd0);
    check({name, "_busy"},     {31'b0, bus.busy},     32'd0);
    check({name, "_overflow"}, {31'b0, bus.overflow}, 32'd0);
    check({name, "_level"},    {29'b0, bus.level},    32'd0);
  endtask

  initial begin : stimulus
    int t, tt, f1, r0;
    logic [15:0] burst [6];
    burst[0] = 16'h0101; burst[1] = 16'h0202; burst[2] = 16'h0303;
    burst[3] = 16'h0404; burst[4] = 16'h0505; burst[5] = 16'h0606;

    bus.in          = '0;
    bus.input_ready = 1'b0;
    rst             = 1'b1;
    repeat (3) @(negedge ck);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge ck);

    // Single sample 8001: latency, fsync window, busy fall.
    push(16'h8001, 1, t);
    check("t1_level_t1", {29'b0, bus.level}, 32'd1);
    check("t1_busy_t1", {31'b0, bus.busy}, 32'd1);
    goto(t + 3);
    check("t1_fsync_t3", {31'b0, bus.fsync}, 32'd1);
    check("t1_sdata_t3", {31'b0, bus.sdata}, 32'd1);
    check("t1_sclk_t3", {31'b0, bus.sclk}, 32'd0);
    goto(t + 5);
    check("t1_sclk_t5", {31'b0, bus.sclk}, 32'd1);
    goto(t + 6);
    check("t1_fsync_t6", {31'b0, bus.fsync}, 32'd1);
    goto(t + 7);
    check("t1_fsync_t7", {31'b0, bus.fsync}, 32'd0);
    goto(t + 70);
    check("t1_busy_t70", {31'b0, bus.busy}, 32'd1);
    goto(t + 71);
    check("t1_busy_t71", {31'b0, bus.busy}, 32'd0);
    check("t1_drained", exp_q.size(), 32'd0);

    // Back-to-back 1234, ABCD: gap plus load between frames.
    @(negedge ck);
    push(16'h1234, 1, t);
    push(16'hABCD, 1, tt);
    wait_fsync(10, f1);
    check("t2_first_fsync_cycle", f1, t + 3);
    goto(f1 + 63);
    check("t2_last_bit_sclk", {31'b0, bus.sclk}, 32'd1);
    for (int c = 64; c <= 68; c++) begin
      goto(f1 + c);
      check("t2_gap_sclk_low", {31'b0, bus.sclk}, 32'd0);
      check("t2_gap_fsync_low", {31'b0, bus.fsync}, 32'd0);
    end
    goto(f1 + FRAME);
    check("t2_second_fsync", {31'b0, bus.fsync}, 32'd1);
    wait_idle(400, "t2");
    check("t2_overflow", {31'b0, bus.overflow}, 32'd0);

    // Six pushes into a 4-deep FIFO: sixth dropped, overflow sticky.
    @(negedge ck);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("t3_ovf_before", {31'b0, bus.overflow}, 32'd0);
      push(burst[i], (i < 5), tt);
      if (i == 0) t = tt;
    end
    check("t3_ovf_t6", {31'b0, bus.overflow}, 32'd1);
    check("t3_level_t6", {29'b0, bus.level}, 32'd4);
    wait_idle(5 * FRAME + 50, "t3");
    check("t3_ovf_held", {31'b0, bus.overflow}, 32'd1);
    rst = 1'b1;
    @(negedge ck);
    @(negedge ck);
    check_zero_outputs("t3_reset");
    rst = 1'b0;
    @(negedge ck);

    // Fill to four during a frame, push on the LOAD cycle while full.
    push(16'h1111, 1, t);
    repeat (2) @(negedge ck);
    push(16'h2222, 1, tt);
    push(16'h3333, 1, tt);
    push(16'h4444, 1, tt);
    push(16'h5555, 1, tt);
    goto(t + 70);
    check("t4_level_gap", {29'b0, bus.level}, 32'd4);
    goto(t + 71);
    check("t4_level_load", {29'b0, bus.level}, 32'd4);
    push(16'h6666, 1, tt);
    check("t4_level_after", {29'b0, bus.level}, 32'd4);
    check("t4_overflow", {31'b0, bus.overflow}, 32'd0);
    check("t4_fsync_after_load", {31'b0, bus.fsync}, 32'd1);
    wait_idle(6 * FRAME + 50, "t4");
    check("t4_overflow_end", {31'b0, bus.overflow}, 32'd0);

    // Reset during bit 8, then a clean 7FFF frame.
    @(negedge ck);
    push(16'h5A5A, 1, t);
    goto(t + 32);
    rst = 1'b1;
    exp_q.delete();
    @(negedge ck);
    check_zero_outputs("t5_reset");
    @(negedge ck);
    rst = 1'b0;
    r0 = rises;
    repeat (40) @(negedge ck);
    check("t5_no_sclk", rises, r0);
    check("t5_sclk_idle", {31'b0, bus.sclk}, 32'd0);
    push(16'h7FFF, 1, tt);
    wait_idle(FRAME + 20, "t5");

    // Sign extremes.
    @(negedge ck);
    push(16'h8000, 1, tt);
    push(16'h7FFF, 1, tt);
    wait_idle(2 * FRAME + 20, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
